// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for one pwm instance: ramps duty toward a
// commanded target in fixed steps, changing duty only at PWM period boundaries.
module pwm_ramp_ctrl #(
  parameter int WIDTH        = 4,
  parameter int STEP         = 1,
  parameter int STEP_PERIODS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic             pwm_enable,
  output logic             busy,
  output logic             at_target
);

  localparam int              RW        = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [RW-1:0]   RCNT_LAST = RW'(STEP_PERIODS - 1);
  localparam logic [RW-1:0]   RCNT_ONE  = RW'(1);
  localparam logic [WIDTH-1:0] PCNT_ONE = WIDTH'(1);
  localparam logic [WIDTH:0]  STEP_W    = (WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_pcnt;
  logic [RW-1:0]     r_rcnt;
  logic [WIDTH-1:0]  r_target;
  logic [WIDTH-1:0]  r_duty;
  logic              r_pwm_enable;
  logic [WIDTH-1:0]  w_duty_step;
  logic [WIDTH:0]    w_diff;
  logic              w_period_end;
  logic              w_step_evt;
  logic              w_accept;
  logic              w_cmd_ready;
  logic              w_busy;
  logic              w_at_target;

  assign w_period_end = (r_pcnt == {WIDTH{1'b1}});
  assign w_step_evt   = w_period_end && (r_rcnt == RCNT_LAST);
  assign w_accept     = cmd_valid && w_cmd_ready;

  // Free-running period counter; mirrors the pwm counter since both share reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PCNT_ONE;
    end
  end

  // Counts whole PWM periods between step events; restarts on accept and abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcnt <= '0;
    end else if (abort || w_accept) begin
      r_rcnt <= '0;
    end else if (w_period_end) begin
      r_rcnt <= (r_rcnt == RCNT_LAST) ? '0 : (r_rcnt + RCNT_ONE);
    end else begin
      r_rcnt <= r_rcnt;
    end
  end

  // Next duty on a step event, computed one bit wider so it clamps instead of wrapping.
  always_comb begin
    w_duty_step = r_duty;
    w_diff      = '0;
    if ({1'b0, r_target} > {1'b0, r_duty}) begin
      w_diff = {1'b0, r_target} - {1'b0, r_duty};
      if (w_diff <= STEP_W) begin
        w_duty_step = r_target;
      end else begin
        w_duty_step = r_duty + STEP_W[WIDTH-1:0];
      end
    end else begin
      w_diff = {1'b0, r_duty} - {1'b0, r_target};
      if (w_diff <= STEP_W) begin
        w_duty_step = r_target;
      end else begin
        w_duty_step = r_duty - STEP_W[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (cmd_target != '0)) begin
            w_state_nxt = ST_RAMP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (w_accept && (cmd_target != r_duty)) begin
            w_state_nxt = ST_RAMP;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_RAMP: begin
          if (w_step_evt && (w_duty_step == r_target)) begin
            w_state_nxt = (r_target == '0) ? ST_IDLE : ST_HOLD;
          end else begin
            w_state_nxt = ST_RAMP;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort masks the handshake in the same cycle so a concurrent command is never acknowledged.
  always_comb begin
    w_busy      = 1'b0;
    w_at_target = 1'b1;
    w_cmd_ready = 1'b0;
    case (r_state)
      ST_RAMP: begin
        w_busy      = 1'b1;
        w_at_target = 1'b0;
        w_cmd_ready = 1'b0;
      end
      ST_IDLE, ST_HOLD: begin
        w_busy      = 1'b0;
        w_at_target = 1'b1;
        w_cmd_ready = !abort;
      end
      default: begin
        w_busy      = 1'b0;
        w_at_target = 1'b1;
        w_cmd_ready = !abort;
      end
    endcase
  end

  // Target latch, duty update and enable; enable follows the next state so it drops with the final zero step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target     <= '0;
      r_duty       <= '0;
      r_pwm_enable <= 1'b0;
    end else if (abort) begin
      r_target     <= '0;
      r_duty       <= '0;
      r_pwm_enable <= 1'b0;
    end else begin
      if (w_accept) begin
        r_target <= cmd_target;
      end else begin
        r_target <= r_target;
      end
      if ((r_state == ST_RAMP) && w_step_evt) begin
        r_duty <= w_duty_step;
      end else begin
        r_duty <= r_duty;
      end
      r_pwm_enable <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign duty       = r_duty;
  assign pwm_enable = r_pwm_enable;
  assign busy       = w_busy;
  assign at_target  = w_at_target;

endmodule
